// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: round-robin scheduler that hands whole SPI transactions
// (CS assert, N bytes, CS release) to one of two requesters at a time and
// drives the byte-level SPI master engine on the owner's behalf.
module spi_xfer_sched #(
  parameter int pDivClk  = 16,
  parameter int pLenW    = 8,
  parameter int pCsSetup = 4,
  parameter int pCsHold  = 4
) (
  input  logic                   iSysClk,
  input  logic                   iSysRst,
  input  logic [1:0]             iReq,
  input  logic [2*pLenW-1:0]     iLen,
  input  logic [2*pDivClk-1:0]   iDiv,
  input  logic [15:0]            iWd,
  output logic [1:0]             oWdAck,
  output logic [7:0]             oRd,
  output logic [1:0]             oRdVd,
  output logic [1:0]             oGnt,
  output logic [1:0]             oDone,
  output logic                   oSPIEn,
  output logic [pDivClk-1:0]     oSPIDiv,
  output logic [7:0]             oMWd,
  output logic                   oMSpiCs,
  input  logic [7:0]             iMRd,
  input  logic                   iMSpiIntr
);

  // One shared wait counter covers both the CS setup and the CS hold/gap phases.
  localparam int pWaitMax = (pCsSetup > pCsHold) ? pCsSetup : pCsHold;
  localparam int pWaitW   = (pWaitMax > 1) ? $clog2(pWaitMax) : 1;
  localparam logic [pWaitW-1:0] cSetupLast = pWaitW'(pCsSetup - 1);
  localparam logic [pWaitW-1:0] cHoldLast  = pWaitW'(pCsHold - 1);
  localparam logic [pWaitW-1:0] cWaitOne   = pWaitW'(1);
  localparam logic [pLenW:0]    cRemOne    = (pLenW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    CSSU,
    LOAD,
    XFER,
    CSHD,
    CSGAP
  } state_t;

  state_t              state_q, state_d;
  logic [pWaitW-1:0]   cnt_q, cnt_d;
  logic [pLenW:0]      rem_q, rem_d;
  logic                owner_q, owner_d;
  logic                rr_q, rr_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                cs_q, cs_d;
  logic [pDivClk-1:0]  div_q, div_d;
  logic [7:0]          mwd_q, mwd_d;
  logic                spiEn_q, spiEn_d;
  logic [7:0]          rd_q, rd_d;
  logic [1:0]          wdAck_q, wdAck_d;
  logic [1:0]          rdVd_q, rdVd_d;
  logic [1:0]          done_q, done_d;

  logic                win;
  logic [pLenW-1:0]    winLen;
  logic [pDivClk-1:0]  winDiv;
  logic [pLenW:0]      winRem;
  logic [1:0]          ownerHot;

  // Pick the arbitration winner: a lone requester always wins, a tie goes to the rr pointer.
  always_comb begin
    win = 1'b0;
    if (iReq == 2'b10) begin
      win = 1'b1;
    end else if (iReq == 2'b11) begin
      win = rr_q;
    end
    winLen   = win ? iLen[2*pLenW-1:pLenW] : iLen[pLenW-1:0];
    winDiv   = win ? iDiv[2*pDivClk-1:pDivClk] : iDiv[pDivClk-1:0];
    winRem   = (winLen == '0) ? {1'b1, {pLenW{1'b0}}} : {1'b0, winLen};
    ownerHot = owner_q ? 2'b10 : 2'b01;
  end

  // Transaction sequencing and the next value of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cs_d    = cs_q;
    div_d   = div_q;
    mwd_d   = mwd_q;
    spiEn_d = spiEn_q;
    rd_d    = rd_q;
    wdAck_d = 2'b00;
    rdVd_d  = 2'b00;
    done_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (iReq != 2'b00) begin
          owner_d = win;
          rr_d    = ~win;
          gnt_d   = win ? 2'b10 : 2'b01;
          cs_d    = 1'b0;
          div_d   = winDiv;
          rem_d   = winRem;
          cnt_d   = '0;
          state_d = CSSU;
        end
      end
      CSSU: begin
        if (cnt_q == cSetupLast) begin
          cnt_d   = '0;
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + cWaitOne;
        end
      end
      LOAD: begin
        mwd_d   = owner_q ? iWd[15:8] : iWd[7:0];
        wdAck_d = ownerHot;
        spiEn_d = 1'b1;
        state_d = XFER;
      end
      XFER: begin
        if (iMSpiIntr) begin
          spiEn_d = 1'b0;
          rd_d    = iMRd;
          rdVd_d  = ownerHot;
          rem_d   = rem_q - cRemOne;
          cnt_d   = '0;
          state_d = (rem_q == cRemOne) ? CSHD : LOAD;
        end
      end
      CSHD: begin
        if (cnt_q == cHoldLast) begin
          cs_d    = 1'b1;
          done_d  = ownerHot;
          gnt_d   = 2'b00;
          cnt_d   = '0;
          state_d = CSGAP;
        end else begin
          cnt_d = cnt_q + cWaitOne;
        end
      end
      CSGAP: begin
        if (cnt_q == cHoldLast) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + cWaitOne;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops CS and the engine enable at once.
  always_ff @(posedge iSysClk or posedge iSysRst) begin
    if (iSysRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      gnt_q   <= 2'b00;
      cs_q    <= 1'b1;
      div_q   <= '1;
      mwd_q   <= 8'h00;
      spiEn_q <= 1'b0;
      rd_q    <= 8'h00;
      wdAck_q <= 2'b00;
      rdVd_q  <= 2'b00;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cs_q    <= cs_d;
      div_q   <= div_d;
      mwd_q   <= mwd_d;
      spiEn_q <= spiEn_d;
      rd_q    <= rd_d;
      wdAck_q <= wdAck_d;
      rdVd_q  <= rdVd_d;
      done_q  <= done_d;
    end
  end

  assign oWdAck  = wdAck_q;
  assign oRd     = rd_q;
  assign oRdVd   = rdVd_q;
  assign oGnt    = gnt_q;
  assign oDone   = done_q;
  assign oSPIEn  = spiEn_q;
  assign oSPIDiv = div_q;
  assign oMWd    = mwd_q;
  assign oMSpiCs = cs_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched: directed bench for the SPI transaction scheduler with a
// simple echoing engine model and per-requester byte sources.
module tb_spi_xfer_sched;

  localparam int pDivClk  = 16;
  localparam int pLenW    = 8;
  localparam int pCsSetup = 4;
  localparam int pCsHold  = 4;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [1:0]           iReq;
  logic [2*pLenW-1:0]   iLen;
  logic [2*pDivClk-1:0] iDiv;
  logic [15:0]          iWd;
  logic [1:0]           oWdAck;
  logic [7:0]           oRd;
  logic [1:0]           oRdVd;
  logic [1:0]           oGnt;
  logic [1:0]           oDone;
  logic                 oSPIEn;
  logic [pDivClk-1:0]   oSPIDiv;
  logic [7:0]           oMWd;
  logic                 oMSpiCs;
  logic [7:0]           iMRd;
  logic                 iMSpiIntr;
  logic                 engIntr;
  logic                 spurIntr;

  int checks = 0;
  int errors = 0;

  // Monitor state, written only by the monitor process.
  int ackCnt[2]  = '{0, 0};
  int rdCnt[2]   = '{0, 0};
  int doneCnt[2] = '{0, 0};
  int violations = 0;
  logic [7:0] mwdLog[$];
  logic [7:0] rdLog[$];
  int gntLog[$];
  int setupLog[$];
  int gapLog[$];
  logic [1:0] prevGnt = 2'b00;
  logic prevCs = 1'b1;
  int csLowRun = 0;
  bit armed = 1'b0;
  int highRun = 0;
  bit seenFall = 1'b0;

  spi_xfer_sched #(
    .pDivClk (pDivClk),
    .pLenW   (pLenW),
    .pCsSetup(pCsSetup),
    .pCsHold (pCsHold)
  ) dut (
    .iSysClk  (clock),
    .iSysRst  (reset),
    .iReq     (iReq),
    .iLen     (iLen),
    .iDiv     (iDiv),
    .iWd      (iWd),
    .oWdAck   (oWdAck),
    .oRd      (oRd),
    .oRdVd    (oRdVd),
    .oGnt     (oGnt),
    .oDone    (oDone),
    .oSPIEn   (oSPIEn),
    .oSPIDiv  (oSPIDiv),
    .oMWd     (oMWd),
    .oMSpiCs  (oMSpiCs),
    .iMRd     (iMRd),
    .iMSpiIntr(iMSpiIntr)
  );

  always #5 clock = ~clock;

  // Byte source: requester 0 starts with A5,5A,3C, otherwise a simple counting pattern.
  function automatic logic [7:0] byteFor(input int r, input int k);
    logic [7:0] tab [3];
    tab[0] = 8'hA5;
    tab[1] = 8'h5A;
    tab[2] = 8'h3C;
    if (r == 0 && k < 3) return tab[k];
    return 8'((k * 7) + (r * 16) + 1);
  endfunction

  assign iWd       = {byteFor(1, ackCnt[1]), byteFor(0, ackCnt[0])};
  assign iMSpiIntr = engIntr | spurIntr;

  // Engine model: sees enable, works two more cycles, then returns the inverted tx byte.
  initial begin
    engIntr = 1'b0;
    iMRd    = 8'h00;
    forever begin
      @(negedge clock);
      if (oSPIEn === 1'b1) begin
        repeat (2) @(negedge clock);
        iMRd    = ~oMWd;
        engIntr = 1'b1;
        @(negedge clock);
        engIntr = 1'b0;
      end
    end
  end

  // Monitor: counts pulses, logs bytes/grants, measures CS timing and flags protocol violations.
  always @(negedge clock) begin
    for (int r = 0; r < 2; r++) begin
      if (oWdAck[r]) begin
        ackCnt[r]++;
        mwdLog.push_back(oMWd);
        if (!oGnt[r]) violations++;
      end
      if (oRdVd[r]) begin
        rdCnt[r]++;
        rdLog.push_back(oRd);
        if (!oGnt[r]) violations++;
      end
      if (oDone[r]) begin
        doneCnt[r]++;
        if (!prevGnt[r]) violations++;
      end
    end
    if (oGnt == 2'b11) violations++;
    if (oGnt != 2'b00 && prevGnt != 2'b00 && oMSpiCs != prevCs) violations++;
    if (oGnt != 2'b00 && prevGnt == 2'b00) gntLog.push_back(oGnt[1] ? 1 : 0);
    if (oMSpiCs) begin
      csLowRun = 0;
      armed    = 1'b1;
    end else if (armed) begin
      if (oSPIEn) begin
        setupLog.push_back(csLowRun);
        armed = 1'b0;
      end else begin
        csLowRun++;
      end
    end
    if (oMSpiCs) begin
      highRun++;
    end else begin
      if (highRun > 0) begin
        if (seenFall) gapLog.push_back(highRun);
        seenFall = 1'b1;
      end
      highRun = 0;
    end
    prevGnt = oGnt;
    prevCs  = oMSpiCs;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [7:0] len0, input logic [7:0] len1,
                               input logic [15:0] div0, input logic [15:0] div1);
    iLen = {len1, len0};
    iDiv = {div1, div0};
    iReq = req;
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic waitGnt(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (oGnt != 2'b00) begin
        g = oGnt;
        break;
      end
    end
  endtask

  task automatic waitDone(input int r, input int maxCyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clock);
      if (oDone[r]) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge clock);
  endtask

  initial begin
    logic [1:0] g;
    bit seen;
    int ack0Snap, rd0Snap, done0Snap, ack1Snap, rd1Snap, done1Snap, done1Base;
    int rdTotSnap, sz;

    spurIntr = 1'b0;
    applyStimulus(2'b00, 8'd0, 8'd0, 16'd0, 16'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // Reset values while reset is still held.
    checkOutput("rst_spien", 32'(oSPIEn), 32'h0);
    checkOutput("rst_div",   32'(oSPIDiv), 32'hFFFF);
    checkOutput("rst_mwd",   32'(oMWd), 32'h0);
    checkOutput("rst_cs",    32'(oMSpiCs), 32'h1);
    checkOutput("rst_gnt",   32'(oGnt), 32'h0);
    checkOutput("rst_wdack", 32'(oWdAck), 32'h0);
    checkOutput("rst_rdvd",  32'(oRdVd), 32'h0);
    checkOutput("rst_done",  32'(oDone), 32'h0);
    checkOutput("rst_rd",    32'(oRd), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // T1: req0 alone, three bytes, engine echoes the inverted byte.
    $display("[TB] T1 single requester, 3 bytes");
    applyStimulus(2'b01, 8'd3, 8'd0, 16'd4, 16'd0);
    waitGnt(g);
    checkOutput("t1_gnt", 32'(g), 32'h1);
    checkOutput("t1_cs_low_at_grant", 32'(oMSpiCs), 32'h0);
    iReq = 2'b00;
    waitDone(0, 300, seen);
    checkOutput("t1_done_seen", 32'(seen), 32'h1);
    checkOutput("t1_div", 32'(oSPIDiv), 32'd4);
    checkOutput("t1_acks", 32'(ackCnt[0]), 32'd3);
    checkOutput("t1_rdvd", 32'(rdCnt[0]), 32'd3);
    checkOutput("t1_done_cnt", 32'(doneCnt[0]), 32'd1);
    sz = mwdLog.size();
    checkOutput("t1_mwd", {8'h0, mwdLog[sz-3], mwdLog[sz-2], mwdLog[sz-1]}, 32'h00A55A3C);
    sz = rdLog.size();
    checkOutput("t1_rd", {8'h0, rdLog[sz-3], rdLog[sz-2], rdLog[sz-1]}, 32'h005AA5C3);
    // CS is low for the pCsSetup setup cycles plus the one LOAD cycle before enable rises.
    checkOutput("t1_setup", 32'(setupLog[setupLog.size()-1]), 32'(pCsSetup + 1));
    checkOutput("t1_cs_idle", 32'(oMSpiCs), 32'h1);

    // T2: simultaneous requests after reset, req0 first then req1.
    $display("[TB] T2 simultaneous requests");
    doReset();
    applyStimulus(2'b11, 8'd1, 8'd1, 16'd2, 16'd3);
    waitGnt(g);
    checkOutput("t2_first_gnt", 32'(g), 32'h1);
    iReq = 2'b10;
    waitDone(0, 300, seen);
    checkOutput("t2_done0", 32'(seen), 32'h1);
    waitGnt(g);
    checkOutput("t2_second_gnt", 32'(g), 32'h2);
    iReq = 2'b00;
    waitDone(1, 300, seen);
    checkOutput("t2_done1", 32'(seen), 32'h1);
    // CS stays high for the pCsHold gap plus the arbitration cycle in IDLE.
    checkOutput("t2_cs_gap", 32'(gapLog[gapLog.size()-1]), 32'(pCsHold + 1));

    // T3: both held for four transactions, grants must alternate.
    $display("[TB] T3 round-robin fairness");
    done0Snap = doneCnt[0];
    done1Snap = doneCnt[1];
    applyStimulus(2'b11, 8'd1, 8'd1, 16'd2, 16'd3);
    for (int i = 0; i < 4; i++) begin
      waitGnt(g);
      checkOutput($sformatf("t3_gnt%0d", i), 32'(g), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i == 3) iReq = 2'b00;
      waitDone((i % 2 == 0) ? 0 : 1, 300, seen);
    end
    checkOutput("t3_done0", 32'(doneCnt[0] - done0Snap), 32'd2);
    checkOutput("t3_done1", 32'(doneCnt[1] - done1Snap), 32'd2);

    // T4: length 0 means 256 bytes.
    $display("[TB] T4 length zero");
    ack0Snap  = ackCnt[0];
    rd0Snap   = rdCnt[0];
    done0Snap = doneCnt[0];
    applyStimulus(2'b01, 8'd0, 8'd0, 16'd1, 16'd0);
    waitGnt(g);
    checkOutput("t4_gnt", 32'(g), 32'h1);
    iReq = 2'b00;
    waitDone(0, 4000, seen);
    checkOutput("t4_done_seen", 32'(seen), 32'h1);
    checkOutput("t4_acks", 32'(ackCnt[0] - ack0Snap), 32'd256);
    checkOutput("t4_rdvd", 32'(rdCnt[0] - rd0Snap), 32'd256);
    checkOutput("t4_done_cnt", 32'(doneCnt[0] - done0Snap), 32'd1);

    // T5: asynchronous reset during the second byte, then a fresh req1 transaction.
    $display("[TB] T5 reset mid-transaction");
    ack0Snap  = ackCnt[0];
    done0Snap = doneCnt[0];
    done1Base = doneCnt[1];
    applyStimulus(2'b01, 8'd3, 8'd0, 16'd4, 16'd0);
    waitGnt(g);
    iReq = 2'b00;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (ackCnt[0] - ack0Snap >= 2) break;
    end
    checkOutput("t5_in_xfer_byte2", 32'(ackCnt[0] - ack0Snap), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_cs", 32'(oMSpiCs), 32'h1);
    checkOutput("t5_spien", 32'(oSPIEn), 32'h0);
    checkOutput("t5_gnt", 32'(oGnt), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("t5_no_done", 32'(doneCnt[0] - done0Snap), 32'd0);
    ack1Snap = ackCnt[1];
    rd1Snap  = rdCnt[1];
    applyStimulus(2'b10, 8'd0, 8'd2, 16'd0, 16'd6);
    waitGnt(g);
    checkOutput("t5_gnt1", 32'(g), 32'h2);
    iReq = 2'b00;
    waitDone(1, 300, seen);
    checkOutput("t5_done1", 32'(doneCnt[1] - done1Base), 32'd1);
    checkOutput("t5_acks1", 32'(ackCnt[1] - ack1Snap), 32'd2);
    checkOutput("t5_rdvd1", 32'(rdCnt[1] - rd1Snap), 32'd2);

    // T6: spurious engine pulses in IDLE and CSSU must be ignored.
    $display("[TB] T6 spurious interrupts");
    repeat (2) @(negedge clock);
    rdTotSnap = rdCnt[0] + rdCnt[1];
    spurIntr = 1'b1;
    @(negedge clock);
    spurIntr = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("t6_idle_rdvd", 32'(rdCnt[0] + rdCnt[1] - rdTotSnap), 32'd0);
    ack0Snap = ackCnt[0];
    rd0Snap  = rdCnt[0];
    applyStimulus(2'b01, 8'd2, 8'd0, 16'd3, 16'd0);
    waitGnt(g);
    spurIntr = 1'b1;
    iReq = 2'b00;
    @(negedge clock);
    spurIntr = 1'b0;
    checkOutput("t6_cssu_rdvd", 32'(rdCnt[0] - rd0Snap), 32'd0);
    waitDone(0, 300, seen);
    checkOutput("t6_done", 32'(seen), 32'h1);
    checkOutput("t6_acks", 32'(ackCnt[0] - ack0Snap), 32'd2);
    checkOutput("t6_rdvd", 32'(rdCnt[0] - rd0Snap), 32'd2);

    // Protocol invariants gathered by the monitor over the whole run.
    checkOutput("invariants", 32'(violations), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
